// File: rtl/disp_pkg.sv
// Shared definitions for the display page scheduler: source geometry,
// FSM encoding and a helper that slices one source word out of the bus.
package disp_pkg;

    localparam int NSRC   = 4;
    localparam int PAGE_W = 2;
    localparam int DATA_W = 16;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_ALERT  = 1'b1
    } state_t;

    function automatic logic [DATA_W-1:0] src_word(
        input logic [NSRC*DATA_W-1:0] data,
        input logic [PAGE_W-1:0]      idx
    );
        return data[idx*DATA_W +: DATA_W];
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and a
// one-cycle pulse on each accepted 0->1 transition.
module btn_debounce #(
    parameter int DEB_CNT = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_pulse
);

    localparam int CNT_W = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;

    logic             sync1_reg;
    logic             sync2_reg;
    logic             stable_reg;
    logic             pulse_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_reg  <= 1'b0;
            sync2_reg  <= 1'b0;
            stable_reg <= 1'b0;
            pulse_reg  <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            sync1_reg <= btn_raw;
            sync2_reg <= sync1_reg;
            pulse_reg <= 1'b0;
            // The counter measures how long the new level has persisted;
            // any return to the accepted level restarts the measurement.
            if (sync2_reg == stable_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_W'(DEB_CNT - 1)) begin
                stable_reg <= sync2_reg;
                cnt_reg    <= '0;
                pulse_reg  <= sync2_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign btn_pulse = pulse_reg;

endmodule

// File: rtl/disp_page_sched.sv
// Chooses which 16-bit value the 7-segment scanner shows: one of four debug
// sources (manual paging or timed rotation) or a preempting alert value.
module disp_page_sched
    import disp_pkg::*;
#(
    parameter int DEB_CNT    = 1_000_000,
    parameter int ROT_CNT    = 50_000_000,
    parameter int ALERT_HOLD = 100_000_000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NSRC*DATA_W-1:0]   src_data,
    input  logic [NSRC-1:0]          src_valid,
    input  logic                     btn_next,
    input  logic                     mode_auto,
    input  logic                     alert_req,
    input  logic [DATA_W-1:0]        alert_data,
    output logic [DATA_W-1:0]        disp_y,
    output logic [PAGE_W-1:0]        page,
    output logic                     alert_active,
    output logic                     blank
);

    localparam int ROT_W  = (ROT_CNT > 1) ? $clog2(ROT_CNT) : 1;
    localparam int HOLD_W = (ALERT_HOLD > 1) ? $clog2(ALERT_HOLD) : 1;

    state_t              state_reg, state_next;
    logic [PAGE_W-1:0]   page_reg, page_next;
    logic [ROT_W-1:0]    rot_cnt_reg, rot_cnt_next;
    logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
    logic [DATA_W-1:0]   alert_val_reg, alert_val_next;
    logic                alert_prev_reg;
    logic [DATA_W-1:0]   disp_y_reg, disp_y_next;
    logic                blank_reg, blank_next;

    logic                next_pulse;
    logic                alert_rise;
    logic                any_valid;
    logic                rot_wrap;
    logic                hold_done;
    logic                skip;
    logic                advance;
    logic [PAGE_W-1:0]   search_page;
    logic [NSRC-1:0]     cand_valid;
    logic [PAGE_W-1:0]   cand_idx [NSRC];

    btn_debounce #(
        .DEB_CNT (DEB_CNT)
    ) u_btn_debounce (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_next),
        .btn_pulse (next_pulse)
    );

    // Candidate gi is page+gi+1; the last candidate wraps back to page itself.
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_cand
        assign cand_idx[gi]   = page_reg + PAGE_W'(gi + 1);
        assign cand_valid[gi] = src_valid[cand_idx[gi]];
    end

    always_comb begin
        search_page = page_reg;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (cand_valid[i]) search_page = cand_idx[i];
        end
    end

    assign any_valid  = |src_valid;
    assign alert_rise = alert_req & ~alert_prev_reg;
    assign rot_wrap   = (rot_cnt_reg == ROT_W'(ROT_CNT - 1));
    assign hold_done  = (hold_cnt_reg == HOLD_W'(ALERT_HOLD - 1));

    always_comb begin
        state_next     = state_reg;
        page_next      = page_reg;
        rot_cnt_next   = rot_cnt_reg;
        hold_cnt_next  = hold_cnt_reg;
        alert_val_next = alert_val_reg;
        skip           = 1'b0;
        advance        = 1'b0;
        case (state_reg)
            ST_NORMAL: begin
                if (alert_rise) begin
                    // Entry wins over any same-cycle page or timer event.
                    state_next     = ST_ALERT;
                    alert_val_next = alert_data;
                    hold_cnt_next  = '0;
                end else begin
                    if (!mode_auto || rot_wrap || next_pulse) begin
                        rot_cnt_next = '0;
                    end else begin
                        rot_cnt_next = rot_cnt_reg + 1'b1;
                    end
                    skip    = ~src_valid[page_reg] & any_valid;
                    advance = skip | next_pulse | (mode_auto & rot_wrap);
                    if (advance && any_valid) page_next = search_page;
                end
            end
            ST_ALERT: begin
                if (alert_rise) begin
                    alert_val_next = alert_data;
                    hold_cnt_next  = '0;
                end else if (hold_done || next_pulse) begin
                    state_next = ST_NORMAL;
                end else begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            default: state_next = ST_NORMAL;
        endcase
    end

    always_comb begin
        disp_y_next = '0;
        blank_next  = 1'b1;
        if (state_reg == ST_ALERT) begin
            disp_y_next = alert_val_reg;
            blank_next  = 1'b0;
        end else if (src_valid[page_reg]) begin
            disp_y_next = src_word(src_data, page_reg);
            blank_next  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_NORMAL;
            page_reg       <= '0;
            rot_cnt_reg    <= '0;
            hold_cnt_reg   <= '0;
            alert_val_reg  <= '0;
            alert_prev_reg <= 1'b0;
            disp_y_reg     <= '0;
            blank_reg      <= 1'b1;
        end else begin
            state_reg      <= state_next;
            page_reg       <= page_next;
            rot_cnt_reg    <= rot_cnt_next;
            hold_cnt_reg   <= hold_cnt_next;
            alert_val_reg  <= alert_val_next;
            alert_prev_reg <= alert_req;
            disp_y_reg     <= disp_y_next;
            blank_reg      <= blank_next;
        end
    end

    assign disp_y       = disp_y_reg;
    assign page         = page_reg;
    assign alert_active = (state_reg == ST_ALERT);
    assign blank        = blank_reg;

endmodule
